pipeline_ctrl: RTL and testbench

Central stall/flush controller for the RV32I 5-stage pipeline. Drives the enable and bubble/flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB from four sources:
- load-use hazards detected in ID;
- taken branches/jumps resolved in EX;
- data-memory wait states in MEM;
- halt requests retiring in WB.

Contains a small FSM (run / memory wait / halted / error), a memory-wait timeout and saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: stage enables, IF_ID flush and ID_EX bubble.
// Control outputs are combinational from state and inputs; state and counters update on the rising edge.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALTED, S_ERROR} state_t;

  state_t           state_q, state_d;
  logic [15:0]      frz_cnt_q, frz_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, mem_freeze, active, timeout;
  logic pc_en_c, if_id_en_c, back_en_c, flush_c, bubble_c;

  assign load_use = ex_mem_rd & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mem_freeze = dmem_req & ~dmem_ready;
  assign active     = (state_q == S_RUN) | (state_q == S_MEM_WAIT);
  // The current freeze cycle is number frz_cnt_q+1; reaching the limit ends in ERROR.
  assign timeout    = ({1'b0, frz_cnt_q} + 17'd1) >= 17'(MEM_TIMEOUT);

  always_comb begin
    pc_en_c    = 1'b0;
    if_id_en_c = 1'b0;
    back_en_c  = 1'b0;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    if (active && !mem_freeze) begin
      back_en_c = 1'b1;
      if (branch_taken) begin
        pc_en_c    = 1'b1;
        if_id_en_c = 1'b1;
        flush_c    = 1'b1;
        bubble_c   = 1'b1;
      end else if (load_use) begin
        bubble_c = 1'b1;
      end else begin
        pc_en_c    = 1'b1;
        if_id_en_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (mem_freeze)    state_d = timeout ? S_ERROR : S_MEM_WAIT;
        else if (halt_req) state_d = S_HALTED;
      end
      S_MEM_WAIT: begin
        if (!mem_freeze)   state_d = S_RUN;
        else if (timeout)  state_d = S_ERROR;
      end
      S_HALTED: if (resume) state_d = S_RUN;
      default:  state_d = S_ERROR;
    endcase

    frz_cnt_d = (active && mem_freeze) ? frz_cnt_q + 16'd1 : 16'd0;

    stall_cnt_d = stall_cnt_q;
    if (active && !pc_en_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (flush_c && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      frz_cnt_q   <= 16'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frz_cnt_q   <= frz_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Gate with reset so every control output is forced low while reset is held.
  assign pc_en        = rst & pc_en_c;
  assign if_id_en     = rst & if_id_en_c;
  assign id_ex_en     = rst & back_en_c;
  assign ex_mem_en    = rst & back_en_c;
  assign mem_wb_en    = rst & back_en_c;
  assign if_id_flush  = rst & flush_c;
  assign id_ex_bubble = rst & bubble_c;
  assign halted       = rst & (state_q == S_HALTED);
  assign err          = rst & (state_q == S_ERROR);
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_rd, branch_taken;
  logic       dmem_req, dmem_ready, halt_req, resume;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_bubble, halted, err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [4:0] en;

  int tests  = 0;
  int failed = 0;
  int stall_exp = 0;
  int flush_exp = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .halted(halted), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_rd = 1'b0; branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_mem_rd = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    branch_taken = 1'b1; halt_req = 1'b1;
    #2;
    tests++; if ({en, if_id_flush, id_ex_bubble, halted, err} !== 9'd0) begin failed++;
      $display("FAIL reset_ctrl: got %b exp 000000000", {en, if_id_flush, id_ex_bubble, halted, err}); end
    tests++; if ({stall_cnt, flush_cnt} !== 8'd0) begin failed++;
      $display("FAIL reset_cnt: got %h exp 00", {stall_cnt, flush_cnt}); end
    step();
    rst = 1'b1;
    idle();
    #1;
    tests++; if ({en, if_id_flush, id_ex_bubble} !== 7'b11111_00) begin failed++;
      $display("FAIL reset_release: got %b exp 1111100", {en, if_id_flush, id_ex_bubble}); end
    step();
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    tests++; if ({en, if_id_flush, id_ex_bubble} !== 7'b00111_01) begin failed++;
      $display("FAIL load_use: got %b exp 0011101", {en, if_id_flush, id_ex_bubble}); end
    step(); stall_exp++;
    idle();
    #1;
    tests++; if ({en, id_ex_bubble} !== 6'b11111_0) begin failed++;
      $display("FAIL load_use_next: got %b exp 111110", {en, id_ex_bubble}); end
    tests++; if (stall_cnt !== 4'(stall_exp)) begin failed++;
      $display("FAIL load_use_cnt: got %0d exp %0d", stall_cnt, stall_exp); end
    step();
  endtask

  task automatic test_x0_and_unused();
    ex_mem_rd = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    tests++; if ({pc_en, id_ex_bubble} !== 2'b10) begin failed++;
      $display("FAIL x0_no_stall: got %b exp 10", {pc_en, id_ex_bubble}); end
    step();
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
    #1;
    tests++; if ({pc_en, id_ex_bubble} !== 2'b10) begin failed++;
      $display("FAIL unused_rs2: got %b exp 10", {pc_en, id_ex_bubble}); end
    id_use_rs2 = 1'b1;
    #1;
    tests++; if ({pc_en, if_id_en, id_ex_bubble} !== 3'b001) begin failed++;
      $display("FAIL rs2_stall: got %b exp 001", {pc_en, if_id_en, id_ex_bubble}); end
    step(); stall_exp++;
    idle();
    step();
  endtask

  task automatic test_branch_over_load();
    set_load_use();
    branch_taken = 1'b1;
    #1;
    tests++; if ({en, if_id_flush, id_ex_bubble} !== 7'b11111_11) begin failed++;
      $display("FAIL branch_load: got %b exp 1111111", {en, if_id_flush, id_ex_bubble}); end
    step(); flush_exp++;
    idle();
    #1;
    tests++; if ({stall_cnt, flush_cnt} !== {4'(stall_exp), 4'(flush_exp)}) begin failed++;
      $display("FAIL branch_cnts: got %h exp %h", {stall_cnt, flush_cnt}, {4'(stall_exp), 4'(flush_exp)}); end
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({en, if_id_flush, id_ex_bubble} !== 7'd0) begin failed++;
        $display("FAIL mem_freeze_%0d: got %b exp 0000000", i, {en, if_id_flush, id_ex_bubble}); end
      step(); stall_exp++;
    end
    halt_req = 1'b0; dmem_ready = 1'b1;
    #1;
    tests++; if ({en, if_id_flush, err, halted} !== 8'b11111_100) begin failed++;
      $display("FAIL mem_release: got %b exp 11111100", {en, if_id_flush, err, halted}); end
    step(); flush_exp++;
    idle();
    #1;
    tests++; if ({stall_cnt, flush_cnt, halted} !== {4'(stall_exp), 4'(flush_exp), 1'b0}) begin failed++;
      $display("FAIL mem_cnts: got %h exp %h", {stall_cnt, flush_cnt, halted}, {4'(stall_exp), 4'(flush_exp), 1'b0}); end
    step();
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    #1;
    tests++; if (en !== 5'b11111) begin failed++;
      $display("FAIL halt_req_cycle: got %b exp 11111", en); end
    step();
    halt_req = 1'b0; branch_taken = 1'b1;
    #1;
    tests++; if ({halted, err, en, if_id_flush} !== 8'b10_00000_0) begin failed++;
      $display("FAIL halted: got %b exp 10000000", {halted, err, en, if_id_flush}); end
    step();
    branch_taken = 1'b0; resume = 1'b1;
    #1;
    tests++; if ({halted, stall_cnt, flush_cnt} !== {1'b1, 4'(stall_exp), 4'(flush_exp)}) begin failed++;
      $display("FAIL halted_hold: got %h exp %h", {halted, stall_cnt, flush_cnt}, {1'b1, 4'(stall_exp), 4'(flush_exp)}); end
    step();
    resume = 1'b0;
    #1;
    tests++; if ({halted, en} !== 6'b0_11111) begin failed++;
      $display("FAIL resume: got %b exp 011111", {halted, en}); end
    step();
  endtask

  task automatic test_timeout();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      tests++; if ({err, en} !== 6'd0) begin failed++;
        $display("FAIL timeout_cycle_%0d: got %b exp 000000", k, {err, en}); end
      step(); stall_exp++;
    end
    #1;
    tests++; if ({err, halted, en} !== 7'b10_00000) begin failed++;
      $display("FAIL timeout_err: got %b exp 1000000", {err, halted, en}); end
    dmem_ready = 1'b1; resume = 1'b1; halt_req = 1'b1; branch_taken = 1'b1;
    step(); step();
    tests++; if ({err, halted, en, if_id_flush, stall_cnt} !== {7'b10_00000, 1'b0, 4'(stall_exp)}) begin failed++;
      $display("FAIL err_sticky: got %h exp %h", {err, halted, en, if_id_flush, stall_cnt}, {7'b10_00000, 1'b0, 4'(stall_exp)}); end
    idle();
    rst = 1'b0;
    #2;
    tests++; if ({err, stall_cnt, flush_cnt} !== 9'd0) begin failed++;
      $display("FAIL err_reset: got %h exp 000", {err, stall_cnt, flush_cnt}); end
    stall_exp = 0; flush_exp = 0;
    step();
    rst = 1'b1;
    #1;
    tests++; if ({err, en} !== 6'b0_11111) begin failed++;
      $display("FAIL after_reset: got %b exp 011111", {err, en}); end
    step();
  endtask

  task automatic test_saturate();
    set_load_use();
    for (int i = 0; i < 20; i++) begin
      step();
      if (stall_exp < 15) stall_exp++;
      if (i == 14 || i == 19) begin
        tests++; if (stall_cnt !== 4'(stall_exp)) begin failed++;
          $display("FAIL stall_sat_%0d: got %0d exp %0d", i, stall_cnt, stall_exp); end
      end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_and_unused();
    test_branch_over_load();
    test_mem_wait();
    test_halt();
    test_timeout();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
